if_stage_pc_unit: RTL
=====================

// Module: if_stage_pc_unit
// PURPOSE
//  Instruction-fetch stage: PC register, next-PC select, and IF/ID pipeline register.
//  Consumes PCWrite/IF_ID_write/flush from hazard_detection_unit.
//  Feeds decoded rs/rt fields of the held instruction back to that unit.
//  Keeps saturating stall/flush event counters for performance debug.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value loaded on reset
//  NOP_INSTR   32'h0000_0000  instruction word inserted into IF/ID on flush
//  CNT_WIDTH   16             width of the stall and flush counters
// PORTS
//  clk_in                input   1          rising-edge clock
//  rst_n_in              input   1          asynchronous, active-low reset
//  PCWrite_in            input   1          1: PC may update; 0: PC holds (stall)
//  IF_ID_write_in        input   1          1: IF/ID loads; 0: IF/ID holds
//  flush_in              input   1          1: IF/ID loads NOP_INSTR (branch/jump squash)
//  jump_in               input   1          jump resolved in ID
//  branch_taken_in       input   1          branch & comparator true in ID
//  jump_target_in        input   32         jump destination
//  branch_target_in      input   32         branch destination
//  instr_rdata_in        input   32         instruction memory read data (combinational read)
//  instr_addr_out        output  32         instruction memory address (= PC register)
//  IF_ID_instr_out       output  32         instruction held in IF/ID
//  IF_ID_pc_plus4_out    output  32         PC+4 of the held instruction
//  IF_ID_valid_out       output  1          1: IF/ID holds a real fetched instruction
//  IF_ID_reg_source_out  output  5          IF_ID_instr_out[25:21] (rs)
//  IF_ID_reg_target_out  output  5          IF_ID_instr_out[20:16] (rt)
//  stall_count_out       output  CNT_WIDTH  cycles with PCWrite_in==0, saturating
//  flush_count_out       output  CNT_WIDTH  cycles with flush_in==1, saturating
// BEHAVIOUR
//  Reset (async, rst_n_in low):
//   - PC=RESET_PC; IF_ID_instr=NOP_INSTR; IF_ID_pc_plus4=0; valid=0; both counters=0.
//   - Takes effect immediately, mid-stall or mid-flush included.
//   - First fetch is from RESET_PC on the first edge after release.
//  next_pc (combinational):
//   - jump_in -> jump_target_in; else branch_taken_in -> branch_target_in; else PC+4.
//   - Jump wins if both are asserted.
//   - PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
//   - next_pc[1:0] is forced to 2'b00 before it is registered.
//  PC register: loads next_pc on a clock edge only when PCWrite_in==1; otherwise holds.
//  IF/ID register, priority per edge:
//   - flush_in==1: instr=NOP_INSTR, pc_plus4=0, valid=0 (flush beats IF_ID_write_in==0).
//   - else IF_ID_write_in==1: instr=instr_rdata_in, pc_plus4=PC+4, valid=1.
//   - else: all fields hold.
//  Latency:
//   - Fetch address to IF_ID_instr_out is 1 cycle.
//   - A redirect is visible on instr_addr_out 1 cycle after the jump_in/branch_taken_in edge.
//  Counters:
//   - +1 per edge when their condition is true.
//   - Stick at all-ones, no wrap.
//   - The stall counter counts on PCWrite_in==0 regardless of flush_in.
//  IF_ID_reg_source_out / IF_ID_reg_target_out are purely combinational slices of the IF/ID register.
// STRUCTURE
//  Shared package mips_pkg:
//   - NOP_INSTR, RESET_PC defaults.
//   - Field slice constants (RS_MSB=25, RS_LSB=21, RT_MSB=20, RT_LSB=16).
//   - INSTR_W=32, REG_ADDR_W=5.
//  One sub-module: sat_counter #(WIDTH) (clk, rst_n, inc, count), instantiated twice.
//  PC logic, next-PC mux and IF/ID register stay inline in this module.
// TESTING
//  Reset:
//   - Assert rst_n_in=0 mid-cycle.
//   - Required: instr_addr_out=0, IF_ID_valid_out=0, IF_ID_instr_out=0 and counters=0 immediately, without a clock edge.
//  Sequential fetch:
//   - Release reset; ROM returns 32'h2108_0001 @0 and 32'h8C09_0004 @4.
//   - Required: addr 0, 4, 8 on successive edges.
//   - Required: IF_ID_instr=32'h2108_0001, pc_plus4=4, rs=8, rt=8 after the 1st edge.
//  Stall:
//   - Hold PCWrite_in=0 and IF_ID_write_in=0 for 3 cycles at PC=8.
//   - Required: PC stays 8, IF/ID unchanged, stall_count_out=3.
//  Jump/branch flush:
//   - At PC=12, drive jump_in=1, jump_target=32'h40, flush_in=1.
//   - Required: next PC=32'h40, IF/ID=NOP with valid=0, flush_count_out +1.
//   - Required: branch_taken+jump together selects jump_target.
//  Flush vs hold:
//   - Drive flush_in=1 with IF_ID_write_in=0 and PCWrite_in=0.
//   - Required: IF/ID becomes NOP, PC holds.
//   - Misaligned branch_target 32'h43 loads PC=32'h40.
//  Boundaries:
//   - PC=32'hFFFF_FFFC with no redirect wraps to 0.
//   - With CNT_WIDTH=4, 20 stall cycles leave stall_count_out=4'hF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: data/register widths, reset defaults and
// instruction field positions used by the fetch/decode boundary.
package mips_pkg;

    localparam int INSTR_W    = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [INSTR_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    function automatic logic [REG_ADDR_W-1:0] rs_field(input logic [INSTR_W-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] rt_field(input logic [INSTR_W-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that increments on each enabled clock edge and sticks at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_stage_pc_unit.sv
// Instruction-fetch stage: PC register with jump/branch/sequential next-PC
// select, IF/ID pipeline register with flush, and stall/flush event counters.
module if_stage_pc_unit
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter int unsigned        CNT_WIDTH = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  PCWrite_in,
    input  logic                  IF_ID_write_in,
    input  logic                  flush_in,
    input  logic                  jump_in,
    input  logic                  branch_taken_in,
    input  logic [INSTR_W-1:0]    jump_target_in,
    input  logic [INSTR_W-1:0]    branch_target_in,
    input  logic [INSTR_W-1:0]    instr_rdata_in,
    output logic [INSTR_W-1:0]    instr_addr_out,
    output logic [INSTR_W-1:0]    IF_ID_instr_out,
    output logic [INSTR_W-1:0]    IF_ID_pc_plus4_out,
    output logic                  IF_ID_valid_out,
    output logic [REG_ADDR_W-1:0] IF_ID_reg_source_out,
    output logic [REG_ADDR_W-1:0] IF_ID_reg_target_out,
    output logic [CNT_WIDTH-1:0]  stall_count_out,
    output logic [CNT_WIDTH-1:0]  flush_count_out
);

    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [INSTR_W-1:0] ifid_pc4_q, ifid_pc4_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [INSTR_W-1:0] pc_plus4;
    logic [INSTR_W-1:0] next_pc;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;

        // Jump outranks a taken branch; the PC is always kept word aligned.
        if (jump_in) begin
            next_pc = jump_target_in;
        end else if (branch_taken_in) begin
            next_pc = branch_target_in;
        end else begin
            next_pc = pc_plus4;
        end
        next_pc[1:0] = 2'b00;

        pc_d = PCWrite_in ? next_pc : pc_q;

        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (flush_in) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (IF_ID_write_in) begin
            ifid_instr_d = instr_rdata_in;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .inc   (!PCWrite_in),
        .count (stall_count_out)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .inc   (flush_in),
        .count (flush_count_out)
    );

    assign instr_addr_out       = pc_q;
    assign IF_ID_instr_out      = ifid_instr_q;
    assign IF_ID_pc_plus4_out   = ifid_pc4_q;
    assign IF_ID_valid_out      = ifid_valid_q;
    assign IF_ID_reg_source_out = rs_field(ifid_instr_q);
    assign IF_ID_reg_target_out = rt_field(ifid_instr_q);

endmodule
